// File: rtl/channel_readout_arbiter.sv
// Round-robin burst-grant scheduler between the TDS channel FIFOs and the packet builder.
// Define ARB_STATS_EN to add saturating per-channel grant counters on grant_count.
module channel_readout_arbiter #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned MAX_BURST = 128
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       channel_linked,
    input  logic [NUM_CH-1:0]       channel_fifo_empty,
    input  logic [NUM_CH*CNT_W-1:0] channel_data_counter,
    input  logic [11:0]             counter_th,
    input  logic [11:0]             idle_counter_number_th,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [3:0]              req_ch,
    output logic [CNT_W-1:0]        req_len,
    input  logic                    burst_done,
    output logic                    busy
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]    grant_count
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, GRANT, WAIT_DONE} state_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0]       linked_q;
    logic [NUM_CH-1:0]       empty_q;
    logic [NUM_CH*CNT_W-1:0] cnt_q;
    logic [11:0]             cnt_th_q;
    logic [11:0]             idle_th_q;
    logic [11:0]             idle_tmr [NUM_CH];
    logic [3:0]              rr_ptr_q;
    logic [3:0]              req_ch_q;
    logic [CNT_W-1:0]        req_len_q;

    logic [CNT_W-1:0]        cnt_arr [NUM_CH];
    logic [NUM_CH-1:0]       elig;
    logic                    found;
    logic [3:0]              win_ch;
    logic [CNT_W-1:0]        win_len;
    logic                    latch_grant;
    logic                    accept;
    logic                    done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            linked_q  <= '0;
            empty_q   <= '1;
            cnt_q     <= '0;
            cnt_th_q  <= '0;
            idle_th_q <= '0;
        end else begin
            linked_q  <= channel_linked;
            empty_q   <= channel_fifo_empty;
            cnt_q     <= channel_data_counter;
            cnt_th_q  <= counter_th;
            idle_th_q <= idle_counter_number_th;
        end
    end

    // A zero count is never eligible, even if the empty flag disagrees.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_arr[i] = cnt_q[i*CNT_W +: CNT_W];
            elig[i]    = linked_q[i] && !empty_q[i] && (cnt_arr[i] != '0) &&
                         ((32'(cnt_arr[i]) >= 32'(cnt_th_q)) ||
                          ((idle_th_q != '0) && (idle_tmr[i] >= idle_th_q)));
        end
    end

    // Winner is the eligible channel at the smallest distance past rr_ptr.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        found   = 1'b0;
        win_ch  = '0;
        win_len = '0;
        best_d  = NUM_CH;
        d       = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            d = (i >= 32'(rr_ptr_q)) ? (i - 32'(rr_ptr_q)) : (i + NUM_CH - 32'(rr_ptr_q));
            if (elig[i] && (d < best_d)) begin
                best_d  = d;
                found   = 1'b1;
                win_ch  = 4'(i);
                win_len = (32'(cnt_arr[i]) > MAX_BURST) ? CNT_W'(MAX_BURST) : cnt_arr[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        latch_grant = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (found) begin
                    latch_grant = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (req_ready) begin
                    accept  = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (burst_done) begin
                    done    = 1'b1;
                    state_d = enable ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            req_ch_q  <= '0;
            req_len_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (latch_grant) begin
                req_ch_q  <= win_ch;
                req_len_q <= win_len;
            end
            if (done) begin
                rr_ptr_q <= (32'(req_ch_q) == NUM_CH - 1) ? 4'd0 : req_ch_q + 4'd1;
            end
        end
    end

    // The granted channel's timer holds until the grant is accepted, then clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) idle_tmr[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!linked_q[i] || empty_q[i] || (accept && (32'(req_ch_q) == i))) begin
                    idle_tmr[i] <= '0;
                end else if (!(busy && (32'(req_ch_q) == i)) && (idle_tmr[i] != '1)) begin
                    idle_tmr[i] <= idle_tmr[i] + 12'd1;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_CH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) grant_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (accept && (32'(req_ch_q) == i) && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) grant_count[i*16 +: 16] = grant_cnt[i];
    end
`endif

    assign req_valid = (state_q == GRANT);
    assign busy      = (state_q == GRANT) || (state_q == WAIT_DONE);
    assign req_ch    = req_ch_q;
    assign req_len   = req_len_q;

endmodule

// File: doc/channel_readout_arbiter.md
# channel_readout_arbiter

Round-robin scheduler that decides which TDS channel FIFO the readout packet builder drains next. It sits between the per-channel FIFOs in the channel receiver block and the Ethernet packet builder, on the 160 MHz readout clock. Each channel becomes eligible on an occupancy threshold or an idle timeout. The arbiter hands out one burst grant at a time and waits for the packet builder to finish that burst before scheduling again.

## Interface
Parameters:
- NUM_CH, 8, number of channels arbitrated (1..16)
- CNT_W, 10, width of each channel FIFO occupancy count
- MAX_BURST, 128, maximum words granted per burst (must be < 2^CNT_W)

Ports:
- clk  in  1  readout clock; all logic is synchronous to it
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  scheduling enable; when low, no new grant is issued
- channel_linked  in  NUM_CH  per-channel link-up flag
- channel_fifo_empty  in  NUM_CH  per-channel FIFO empty flag
- channel_data_counter  in  NUM_CH*CNT_W  flattened occupancy counts; channel i occupies bits [i*CNT_W +: CNT_W]
- counter_th  in  12  occupancy threshold; compared zero-extended against the count
- idle_counter_number_th  in  12  idle timeout in cycles; 0 disables the timeout
- req_valid  out  1  grant request to the packet builder
- req_ready  in  1  packet builder accepts the grant
- req_ch  out  4  granted channel index
- req_len  out  CNT_W  number of words granted
- burst_done  in  1  one-cycle pulse; the granted burst is finished
- busy  out  1  a grant is outstanding (GRANT or WAIT_DONE)
- grant_count  out  NUM_CH*16  per-channel grant counters; present only with ARB_STATS_EN

## Operation
- Eligibility of channel i requires all of:
  - channel_linked[i] = 1
  - channel_fifo_empty[i] = 0
  - either count_i >= counter_th, or (idle_counter_number_th != 0 and idle_tmr[i] >= idle_counter_number_th)
- Each channel has a 12-bit idle_tmr:
  - increments each cycle while the FIFO is non-empty and not granted
  - saturates at 4095
  - clears when the FIFO is empty, the channel is unlinked, or the channel is accepted via req_valid & req_ready
- A round-robin pointer rr_ptr (reset 0) sets search order: rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CH. The first eligible channel in that order wins.
- State machine (reset state IDLE):
  - IDLE: if enable, go to SCAN.
  - SCAN: if enable is low, go to IDLE. If any channel is eligible, latch the winner into req_ch and latch req_len = min(count, MAX_BURST), then go to GRANT. Otherwise stay in SCAN.
  - GRANT: hold req_valid = 1, with req_ch and req_len stable. On req_valid & req_ready, go to WAIT_DONE. A grant is never withdrawn, even if the channel unlinks or enable drops.
  - WAIT_DONE: on burst_done, set rr_ptr = req_ch+1 (mod NUM_CH) and go to SCAN, or to IDLE if enable is low.
- burst_done outside WAIT_DONE is ignored.
- req_len is a snapshot. Words that arrive after the snapshot wait for a later grant.
- If counter_th = 0, any non-empty linked channel is eligible.
- If count = 0 while empty = 0 (flag and count skewed), the channel is not eligible. This prevents a zero-length grant.

## Timing
- Reset values:
  - req_valid = 0, req_ch = 0, req_len = 0, busy = 0
  - rr_ptr = 0, all idle_tmr = 0, grant_count = 0
- Eligibility is computed combinationally from registered inputs. The decision registers on the SCAN cycle, and req_valid rises on the next edge. Latency from the threshold being crossed to req_valid is 2 cycles, counting the input register.
- The handshake completes on the cycle where req_valid & req_ready are both high. req_valid falls on the following edge.
- burst_done to the next req_valid is at least 2 cycles: the WAIT_DONE→SCAN transition, then SCAN→GRANT.
- busy is high from the GRANT entry edge through the edge that consumes burst_done.
- Asserting reset_n mid-burst immediately forces IDLE with all outputs at their reset values. The packet builder is reset by the same net.

## Configuration
- ARB_STATS_EN defined:
  - a 16-bit grant counter per channel increments on each accepted grant
  - counters saturate at 0xFFFF and clear only on reset
  - counters are exported on grant_count
- ARB_STATS_EN undefined:
  - the grant_count port and its counters are absent
  - arbitration behaviour is identical

## Test plan
- Threshold grant: counter_th=16, ch3 count rises to 16 with ch3 linked → req_valid with req_ch=3, req_len=16 two cycles later. Hold req_ready low for 5 cycles → req_valid, req_ch and req_len stay stable.
- Round-robin: ch0, ch2 and ch5 all over threshold, rr_ptr=0, burst_done returned each time → grant order 0, 2, 5, 0. After ch5, rr_ptr=6 and the search wraps to ch0.
- Idle timeout: counter_th=100, idle_counter_number_th=50, ch1 holds 4 words → grant with req_len=4 after about 50 cycles. With idle_counter_number_th=0 → no grant ever.
- Burst cap and link gating: ch7 count=300 with MAX_BURST=128 → req_len=128. ch6 over threshold but channel_linked[6]=0 → ch6 never granted.
- Mid-operation events: enable dropped in WAIT_DONE → no new req_valid after burst_done. reset_n pulsed during GRANT → req_valid=0 and busy=0 immediately. Spurious burst_done in SCAN → no state change.
- With ARB_STATS_EN: 3 grants to ch2 → grant_count for ch2 reads 3, all other channels read 0.
